uart_frame_loader: RTL
======================

// Module: uart_frame_loader
// PURPOSE
//  - UART receive front end of the CNV inference design: deserialises usb_uart_rxd and deframes image payloads.
//  - Emits each payload as an 8-bit AXI-Stream into the accelerator input, with tlast on the final payload byte.
//  - Sits between the board UART pin and the inference core's input stream.
// PARAMETERS
//  - CLK_HZ       100_000_000  sys_clock frequency in Hz.
//  - BAUD         115200       UART bit rate; format is 8N1, LSB first.
//  - FRAME_BYTES  3072         payload bytes per frame (32x32x3 image); must be >= 1.
//  - FIFO_DEPTH   16           output FIFO entries; power of two, >= 2.
//  - SYNC_BYTE    8'hA5        frame start marker.
// PORTS
//  - sys_clock      in   1   single clock; all logic is on its rising edge.
//  - reset          in   1   synchronous reset, active-high.
//  - usb_uart_rxd   in   1   asynchronous UART serial input; idles high.
//  - m_axis_tdata   out  8   payload byte.
//  - m_axis_tvalid  out  1   tdata/tlast valid.
//  - m_axis_tready  in   1   downstream accepts the byte.
//  - m_axis_tlast   out  1   high on byte FRAME_BYTES-1 of a frame.
//  - frame_done     out  1   one-cycle pulse when the last payload byte is written to the FIFO.
//  - busy           out  1   high whenever the loader FSM is not in HUNT.
//  - err_framing    out  1   sticky: a stop bit was sampled low.
//  - err_overflow   out  1   sticky: a payload byte arrived while the FIFO was full.
// BEHAVIOUR
//  - Reset values: all outputs 0; the FSM enters HUNT; the FIFO and all counters are cleared.
//  - Reset mid-byte or mid-frame discards the partial byte/frame; nothing is replayed afterwards.
//  - Sticky error flags clear only on reset.
//  - RX timing: usb_uart_rxd passes through a 2-FF synchroniser.
//    - Tick divider: DIV = round(CLK_HZ/(BAUD*16)), minimum 1.
//    - A falling edge while idle starts a bit timer.
//    - Start bit is re-checked 8 ticks after the edge; if it reads high, it is a glitch and the receiver returns to idle.
//    - Data bits are sampled every 16 ticks, LSB first; the stop bit is sampled 16 ticks after bit 7.
//    - Stop bit = 0: byte discarded, err_framing set, receiver waits for the line to go high before re-arming.
//    - Good byte: one-cycle rx_valid strobe with rx_data.
//  - Loader FSM (states HUNT, LOAD, CHECK):
//    - HUNT: bytes other than SYNC_BYTE are dropped. SYNC_BYTE -> LOAD with cnt=0.
//    - LOAD: each byte is pushed to the FIFO with tlast=(cnt==FRAME_BYTES-1), then cnt++. When the last byte is pushed: frame_done pulse, then -> CHECK (macro on) or -> HUNT (macro off).
//    - SYNC_BYTE is ordinary payload in LOAD; there is no re-sync mid-frame.
//    - FIFO full on a push: byte dropped, err_overflow set, frame aborted (-> HUNT, no frame_done, no tlast). Bytes already queued drain normally.
//  - Output stream:
//    - Standard AXI-S: a beat transfers on tvalid&&tready.
//    - tdata/tlast hold stable while tvalid&&!tready.
//    - tvalid never depends on tready.
//    - A simultaneous push and pop on a full FIFO is legal and is not an overflow.
//  - Latency: with the FIFO empty and tready=1, tvalid rises 2 cycles after the rx_valid strobe.
// CONFIGURATION
//  - UART_FRAME_CHECKSUM_EN defined:
//    - Adds output err_checksum (sticky, reset 0).
//    - CHECK state consumes one trailer byte and compares it with the XOR of all payload bytes; a mismatch sets err_checksum. Then -> HUNT.
//    - The trailer is never pushed to the FIFO; busy stays high in CHECK.
//  - Macro undefined: no err_checksum port, no CHECK state, no XOR accumulator; LOAD returns straight to HUNT.
// STRUCTURE
//  - Package uart_frame_loader_pkg: loader_state_t enum {HUNT, LOAD, CHECK}; rx_state_t enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH}; SYNC_BYTE default constant.
//  - Sub-module uart_rx_core (params CLK_HZ, BAUD): synchroniser, tick divider, bit FSM, rx_data/rx_valid/rx_frame_err outputs.
//  - FIFO (9 bits wide: tdata + tlast) and loader FSM live inline in uart_frame_loader.
// TESTING
//  - Bench parameters: CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, 16 clk/bit), FRAME_BYTES=4, FIFO_DEPTH=4.
//  - Send 0x11,0xA5,01,02,03,04 with tready=1 -> beats 01,02,03,04; tlast only on 04; one frame_done pulse; no errors.
//  - Send A5,A5,00,FF,A5 -> payload A5,00,FF,A5 (SYNC_BYTE accepted as data); tlast on the final A5.
//  - Hold tready=0, send A5 + 4 bytes, then A5 + 1 byte -> FIFO full at 4; next byte sets err_overflow and aborts the frame; releasing tready drains 4 beats with tlast on beat 4.
//  - Send a byte with stop bit low, then A5,01..04 -> err_framing=1; the following frame is delivered intact.
//  - Assert reset for 1 cycle in the middle of byte 2 of a frame -> all outputs 0; stream empty; next full frame delivered correctly.
//  - Macro defined: A5,01,02,03,04,04 -> err_checksum stays 0; repeating with trailer 05 -> err_checksum=1; trailer never appears on m_axis.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared types and constants for the UART frame loader and its receiver core.
package uart_frame_loader_pkg;

  typedef enum logic [1:0] {HUNT, LOAD, CHECK} loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Oversampling divider: round(clk_hz / (baud * 16)), never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + baud * 8) / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_frame_loader_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling tick, bit-level FSM.
module uart_rx_core
  import uart_frame_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          sync1_q, sync2_q;
  rx_state_t     state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [3:0]    os_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          tick;

  assign tick           = (tick_cnt_q == TW'(DIV - 1));
  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign rx_frame_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      // The tick phase restarts at every start edge so sampling is centred.
      if (state_q == RX_IDLE || state_q == RX_WAIT_HIGH || tick) tick_cnt_q <= '0;
      else tick_cnt_q <= tick_cnt_q + 1'b1;
      case (state_q)
        RX_IDLE: begin
          if (!sync2_q) begin
            state_q  <= RX_START;
            os_cnt_q <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (os_cnt_q == 4'd7) begin
              os_cnt_q  <= '0;
              bit_idx_q <= '0;
              state_q   <= sync2_q ? RX_IDLE : RX_DATA;
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd15) begin
              shift_q   <= {sync2_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_q <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            os_cnt_q <= os_cnt_q + 4'd1;
            if (os_cnt_q == 4'd15) begin
              if (sync2_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= RX_IDLE;
              end else begin
                err_q   <= 1'b1;
                state_q <= RX_WAIT_HIGH;
              end
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (sync2_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame deframer feeding an 8-bit AXI-Stream through a small FIFO.
// Optional trailer XOR checksum check is enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         BAUD        = 115200,
  parameter int         FRAME_BYTES = 3072,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       usb_uart_rxd,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_done,
  output logic       busy,
  output logic       err_framing,
  output logic       err_overflow
`ifdef UART_FRAME_CHECKSUM_EN
  ,
  output logic       err_checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FRAME_BYTES + 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_frame_err;

  loader_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic             byte_valid_q;
  logic             frame_done_q;
  logic             err_framing_q;
  logic             err_overflow_q;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       xor_q;
  logic             err_checksum_q;
`endif

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [8:0]       rd_word;
  logic             full, pop, push_req, push_ok, push_last;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk_i          (sys_clock),
    .rst_i          (reset),
    .rxd_i          (usb_uart_rxd),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_frame_err_o (rx_frame_err)
  );

  // Stream contract: a beat moves on tvalid && tready; tvalid is the FIFO
  // non-empty flag only, and the head word is held until it is popped.
  assign rd_word       = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? rd_word[7:0] : 8'h00;
  assign m_axis_tlast  = m_axis_tvalid & rd_word[8];
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign full          = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_req      = byte_valid_q & (state_q == LOAD);
  assign push_ok       = push_req & (~full | pop);
  assign push_last     = (cnt_q == CNT_W'(FRAME_BYTES - 1));

  assign frame_done    = frame_done_q;
  assign busy          = (state_q != HUNT);
  assign err_framing   = err_framing_q;
  assign err_overflow  = err_overflow_q;
`ifdef UART_FRAME_CHECKSUM_EN
  assign err_checksum  = err_checksum_q;
`endif

  always_ff @(posedge sys_clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, byte_q};
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q        <= HUNT;
      cnt_q          <= '0;
      byte_q         <= '0;
      byte_valid_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      xor_q          <= '0;
      err_checksum_q <= 1'b0;
`endif
    end else begin
      byte_q       <= rx_data;
      byte_valid_q <= rx_valid;
      frame_done_q <= 1'b0;
      if (rx_frame_err) err_framing_q <= 1'b1;
      if (byte_valid_q) begin
        case (state_q)
          HUNT: begin
            if (byte_q == SYNC_BYTE) begin
              state_q <= LOAD;
              cnt_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              xor_q   <= '0;
`endif
            end
          end
          LOAD: begin
            if (!push_ok) begin
              // No room: drop the byte and abandon the rest of the frame.
              err_overflow_q <= 1'b1;
              state_q        <= HUNT;
            end else begin
`ifdef UART_FRAME_CHECKSUM_EN
              xor_q <= xor_q ^ byte_q;
`endif
              if (push_last) begin
                frame_done_q <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                state_q      <= CHECK;
`else
                state_q      <= HUNT;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
`ifdef UART_FRAME_CHECKSUM_EN
          CHECK: begin
            if (byte_q != xor_q) err_checksum_q <= 1'b1;
            state_q <= HUNT;
          end
`endif
          default: state_q <= HUNT;
        endcase
      end
    end
  end

endmodule
